// File: rtl/irq_vector_controller.sv
// rtl/irq_vector_controller.sv - edge-latched, fixed-priority interrupt redirect with per-source vectors and EPC return
module irq_vector_controller #(
    parameter int          NUM_IRQ    = 8,
    parameter int          ADDR_W     = 32,
    parameter int unsigned VEC_BASE   = 500,
    parameter int unsigned VEC_STRIDE = 4,
    parameter int          ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_next,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               global_en,
    input  logic               return_from_isr,
    output logic [ADDR_W-1:0]  pc_next_final,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               flush,
    output logic               in_isr,
    output logic [ID_W-1:0]    active_id,
    output logic [ADDR_W-1:0]  epc,
    output logic [NUM_IRQ-1:0] pending
);

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_TAKE   = 2'd1;
    localparam logic [1:0] ST_ISR    = 2'd2;

    logic [1:0]         r_state;
    logic [NUM_IRQ-1:0] r_irq_in_d;
    logic [NUM_IRQ-1:0] r_pending;
    logic [ID_W-1:0]    r_active_id;
    logic [ADDR_W-1:0]  r_epc;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_onehot;
    logic [NUM_IRQ-1:0] w_clear;
    logic [ID_W-1:0]    w_winner;
    logic               w_any;
    logic               w_is_take;
    logic               w_ret;
    logic [ADDR_W-1:0]  w_vector;

    assign w_rise     = irq_in & ~r_irq_in_d;
    assign w_eligible = global_en ? (r_pending & irq_mask) : '0;
    assign w_any      = |w_eligible;
    assign w_is_take  = (r_state == ST_TAKE);
    assign w_ret      = (r_state == ST_ISR) && return_from_isr;
    assign w_clear    = w_is_take ? w_onehot : '0;
    assign w_vector   = ADDR_W'(VEC_BASE) + ADDR_W'(r_active_id) * ADDR_W'(VEC_STRIDE);

    // Scan from the top down so the lowest eligible index is the one left standing.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_onehot[i] = (r_active_id == ID_W'(i));
        end
    end

    always_comb begin
        pc_next_final = pc_next;
        irq_ack       = '0;
        flush         = 1'b0;
        if (w_is_take) begin
            pc_next_final = w_vector;
            irq_ack       = w_onehot;
            flush         = 1'b1;
        end else if (w_ret) begin
            pc_next_final = r_epc;
            flush         = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_NORMAL;
            r_irq_in_d  <= '0;
            r_pending   <= '0;
            r_active_id <= '0;
            r_epc       <= '0;
        end else begin
            r_irq_in_d <= irq_in;
            // A fresh edge on the source being acknowledged re-arms it: set wins over clear.
            r_pending  <= (r_pending & ~w_clear) | w_rise;
            case (r_state)
                ST_NORMAL: begin
                    if (w_any) begin
                        r_active_id <= w_winner;
                        r_state     <= ST_TAKE;
                    end
                end
                ST_TAKE: begin
                    r_epc   <= pc_next;
                    r_state <= ST_ISR;
                end
                ST_ISR: begin
                    if (return_from_isr) begin
                        r_state <= ST_NORMAL;
                    end
                end
                default: r_state <= ST_NORMAL;
            endcase
        end
    end

    assign in_isr    = (r_state == ST_TAKE) || (r_state == ST_ISR);
    assign active_id = r_active_id;
    assign epc       = r_epc;
    assign pending   = r_pending;

endmodule
